ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte, such as 0xED "set LEDs" or 0xFF "reset", from the FPGA to the keyboard. It sits beside the PS/2 receiver on the same `ps2c`/`ps2d` lines and drives them open-drain through output-enable signals. `tx_idle` tells the receiver path to ignore the lines while a frame is in flight.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_clk_filter.sv | 43 ++++
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, timing constants and common
// keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        REQ,
        START,
        DATA,
        STOP,
        ACK,
        WAIT_REL
    } tx_state_e;

    localparam int REQ_CYCLES   = 16;
    localparam int FILTER_DEPTH = 8;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    // Nine bits shifted out LSB first: data byte, then odd parity on top.
    function automatic logic [8:0] make_frame(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake plus the open-drain PS/2 pin view of the
// transmitter, bundled so the system side and the transmitter share one port.
interface ps2_host_tx_if;

    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;

    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick
    );

    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher with falling-edge detect; usable by both the receiver
// and the host transmitter on the same line.
module ps2_clk_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [FILTER_DEPTH-1:0] shift_q;
    logic                    level_q;
    logic                    level_d;
    logic                    prev_q;

    // The filtered level only moves on a unanimous window, otherwise it holds.
    always_comb begin
        level_d = level_q;
        if (&shift_q) begin
            level_d = 1'b1;
        end else if (~|shift_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            shift_q <= {line_i, shift_q[FILTER_DEPTH-1:1]};
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    assign level_o = level_q;
    assign fall_o  = prev_q & ~level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, clocked-out frame,
// ACK check and per-edge timeout, driving both lines open-drain.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    ps2_host_tx_if.slave bus
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST     = CW'(REQ_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    tx_state_e               state_q, state_d;
    logic [8:0]              frame_q, frame_d;
    logic [3:0]              bitCnt_q, bitCnt_d;
    logic [CW-1:0]           cycleCnt_q, cycleCnt_d;
    logic                    ok_q, ok_d;
    logic                    clkOe_q, clkOe_d;
    logic                    datOe_q, datOe_d;
    logic                    idle_q, idle_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [FILTER_DEPTH-1:0] datShift_q;
    logic                    datLevel_q, datLevel_d;
    logic                    clkLevel;
    logic                    clkFall;
    logic                    deviceClocked;
    logic                    timeoutHit;

    ps2_clk_filter u_clk_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (bus.ps2c_in),
        .level_o (clkLevel),
        .fall_o  (clkFall)
    );

    // Data pin sees the same window as the clock so the ACK sample lines up.
    always_comb begin
        datLevel_d = datLevel_q;
        if (&datShift_q) begin
            datLevel_d = 1'b1;
        end else if (~|datShift_q) begin
            datLevel_d = 1'b0;
        end
    end

    assign deviceClocked = (state_q == START) || (state_q == DATA) || (state_q == STOP) ||
                           (state_q == ACK)   || (state_q == WAIT_REL);
    assign timeoutHit    = deviceClocked && (cycleCnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bitCnt_d   = bitCnt_q;
        cycleCnt_d = cycleCnt_q;
        ok_d       = ok_q;
        clkOe_d    = clkOe_q;
        datOe_d    = datOe_q;
        idle_d     = idle_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (timeoutHit) begin
            state_d    = IDLE;
            cycleCnt_d = '0;
            clkOe_d    = 1'b0;
            datOe_d    = 1'b0;
            idle_d     = 1'b1;
            err_d      = 1'b1;
        end else begin
            if (deviceClocked) begin
                cycleCnt_d = clkFall ? '0 : cycleCnt_q + CW'(1);
            end
            unique case (state_q)
                IDLE: begin
                    clkOe_d = 1'b0;
                    datOe_d = 1'b0;
                    idle_d  = 1'b1;
                    if (bus.wr_ps2) begin
                        frame_d    = make_frame(bus.din);
                        cycleCnt_d = '0;
                        clkOe_d    = 1'b1;
                        idle_d     = 1'b0;
                        state_d    = RTS;
                    end
                end
                RTS: begin
                    cycleCnt_d = cycleCnt_q + CW'(1);
                    if (cycleCnt_q == INHIBIT_LAST) begin
                        cycleCnt_d = '0;
                        datOe_d    = 1'b1;
                        state_d    = REQ;
                    end
                end
                REQ: begin
                    cycleCnt_d = cycleCnt_q + CW'(1);
                    if (cycleCnt_q == REQ_LAST) begin
                        cycleCnt_d = '0;
                        clkOe_d    = 1'b0;
                        state_d    = START;
                    end
                end
                START: begin
                    if (clkFall) begin
                        datOe_d  = ~frame_q[0];
                        bitCnt_d = '0;
                        state_d  = DATA;
                    end
                end
                DATA: begin
                    if (clkFall) begin
                        if (bitCnt_q == 4'd8) begin
                            datOe_d = 1'b0;
                            state_d = STOP;
                        end else begin
                            frame_d  = {1'b0, frame_q[8:1]};
                            bitCnt_d = bitCnt_q + 4'd1;
                            datOe_d  = ~frame_q[1];
                        end
                    end
                end
                STOP: begin
                    if (clkFall) begin
                        state_d = ACK;
                    end
                end
                ACK: begin
                    if (clkFall) begin
                        ok_d    = ~datLevel_q;
                        state_d = WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (clkLevel && datLevel_q) begin
                        done_d     = ok_q;
                        err_d      = ~ok_q;
                        idle_d     = 1'b1;
                        cycleCnt_d = '0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bitCnt_q   <= '0;
            cycleCnt_q <= '0;
            ok_q       <= 1'b0;
            clkOe_q    <= 1'b0;
            datOe_q    <= 1'b0;
            idle_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            datShift_q <= '1;
            datLevel_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bitCnt_q   <= bitCnt_d;
            cycleCnt_q <= cycleCnt_d;
            ok_q       <= ok_d;
            clkOe_q    <= clkOe_d;
            datOe_q    <= datOe_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            err_q      <= err_d;
            datShift_q <= {bus.ps2d_in, datShift_q[FILTER_DEPTH-1:1]};
            datLevel_q <= datLevel_d;
        end
    end

    assign bus.ps2c_oe      = clkOe_q;
    assign bus.ps2d_oe      = datOe_q;
    assign bus.tx_idle      = idle_q;
    assign bus.tx_done_tick = done_q;
    assign bus.tx_err_tick  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard BFM clocks frames out of the host and the
// captured bits, ticks and timings are compared against a frame-level model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 100;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 40;

    typedef struct {
        logic [7:0] din;
        bit         ackLow;
        int         stopAfter;
        bit         expDone;
        bit         expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic devClkLow = 1'b0;
    logic devDataLow = 1'b0;

    ps2_host_tx_if bus ();

    assign bus.ps2c_in = ~(bus.ps2c_oe | devClkLow);
    assign bus.ps2d_in = ~(bus.ps2d_oe | devDataLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycleNum = 0;
    int doneTotal = 0;
    int errTotal = 0;
    int lowTotal = 0;
    int errCycle = 0;

    logic [10:0] seenBits;
    int          seenCount;
    int          lastFallCycle;
    int          releaseCycle;
    int          doneDelta;
    int          errDelta;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    always @(negedge clk) begin
        if (bus.tx_done_tick) doneTotal++;
        if (bus.tx_err_tick) begin
            errTotal++;
            errCycle = cycleNum;
        end
        if (bus.ps2c_oe) lowTotal++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame-level reference: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] expectedBits(input logic [7:0] d);
        logic [10:0] b;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i + 1] = d[i];
        b[9]  = ($countones(d) % 2 == 0);
        b[10] = 1'b1;
        return b;
    endfunction

    function automatic vec_t mkVec(input logic [7:0] d, input bit ackLow, input int stopAfter);
        vec_t v;
        v.din       = d;
        v.ackLow    = ackLow;
        v.stopAfter = stopAfter;
        v.expDone   = ackLow && (stopAfter >= 12);
        v.expErr    = !v.expDone;
        return v;
    endfunction

    // Issues one request and plays the keyboard side for up to 12 clock pulses.
    task automatic applyStimulus(input vec_t v, input int busyAt, input int resetAt, output bit wasReset);
        int doneStart;
        int errStart;
        int lowStart;
        int w;
        wasReset  = 1'b0;
        seenBits  = '0;
        seenCount = 0;
        doneStart = doneTotal;
        errStart  = errTotal;
        lowStart  = lowTotal;
        @(negedge clk);
        bus.din    = v.din;
        bus.wr_ps2 = 1'b1;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        checkOutput("accept_idle", bus.tx_idle, 0);
        checkOutput("accept_clk_oe", bus.ps2c_oe, 1);
        w = 0;
        while (bus.ps2c_oe && w < INHIBIT + REQ_CYCLES + 10) begin
            @(negedge clk);
            w++;
        end
        releaseCycle  = cycleNum;
        lastFallCycle = cycleNum;
        checkOutput("clk_low_cycles", lowTotal - lowStart, INHIBIT + REQ_CYCLES);
        waitCycles(HALF / 2);
        for (int k = 1; k <= v.stopAfter && !wasReset; k++) begin
            waitCycles(HALF / 2);
            if (k <= 11) begin
                seenBits[k - 1] = bus.ps2d_in;
                seenCount = k;
            end
            waitCycles(HALF / 2);
            devClkLow     = 1'b1;
            lastFallCycle = cycleNum;
            waitCycles(HALF / 2);
            if (k == 11) devDataLow = v.ackLow;
            if (k == busyAt) begin
                bus.din    = 8'h55;
                bus.wr_ps2 = 1'b1;
                @(negedge clk);
                bus.wr_ps2 = 1'b0;
                bus.din    = v.din;
                checkOutput("busy_ignored_idle", bus.tx_idle, 0);
            end
            if (k == resetAt) begin
                rst_n = 1'b0;
                #1;
                checkOutput("midreset_clk_oe", bus.ps2c_oe, 0);
                checkOutput("midreset_dat_oe", bus.ps2d_oe, 0);
                checkOutput("midreset_idle", bus.tx_idle, 1);
                @(negedge clk);
                rst_n    = 1'b1;
                wasReset = 1'b1;
            end
            waitCycles(HALF / 2);
            devClkLow = 1'b0;
            if (k == 12) devDataLow = 1'b0;
        end
        devDataLow = 1'b0;
        if (!wasReset) begin
            w = 0;
            while (!bus.tx_idle && w < 3 * TIMEOUT) begin
                @(negedge clk);
                w++;
            end
        end
        waitCycles(30);
        doneDelta = doneTotal - doneStart;
        errDelta  = errTotal - errStart;
    endtask

    task automatic runVector(input vec_t v, input int busyAt);
        logic [10:0] mask;
        logic [10:0] exp;
        bit          wasReset;
        applyStimulus(v, busyAt, 0, wasReset);
        exp  = expectedBits(v.din);
        mask = 11'((1 << seenCount) - 1);
        if (seenCount > 0) checkOutput($sformatf("frame_bits_%02h", v.din), seenBits & mask, exp & mask);
        checkOutput("done_ticks", doneDelta, v.expDone);
        checkOutput("err_ticks", errDelta, v.expErr);
        checkOutput("end_idle", bus.tx_idle, 1);
        checkOutput("end_oes", {bus.ps2c_oe, bus.ps2d_oe}, 0);
        if (v.stopAfter == 0) begin
            checkRange("start_timeout_latency", errCycle - releaseCycle, TIMEOUT - 5, TIMEOUT + 5);
        end else if (v.stopAfter < 12) begin
            checkRange("edge_timeout_latency", errCycle - lastFallCycle, TIMEOUT + 5, TIMEOUT + 15);
        end
    endtask

    vec_t vecs[$];

    initial begin
        bit wasReset;
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        rst_n      = 1'b0;
        waitCycles(3);
        checkOutput("reset_idle", bus.tx_idle, 1);
        checkOutput("reset_clk_oe", bus.ps2c_oe, 0);
        checkOutput("reset_dat_oe", bus.ps2d_oe, 0);
        checkOutput("reset_done", bus.tx_done_tick, 0);
        checkOutput("reset_err", bus.tx_err_tick, 0);
        rst_n = 1'b1;
        waitCycles(5);

        vecs.push_back(mkVec(PS2_CMD_SET_LED, 1'b1, 12));
        vecs.push_back(mkVec(8'h00, 1'b1, 12));
        vecs.push_back(mkVec(PS2_CMD_RESET, 1'b1, 12));
        vecs.push_back(mkVec(8'h01, 1'b1, 12));
        vecs.push_back(mkVec(8'hA5, 1'b0, 12));
        vecs.push_back(mkVec(8'h3C, 1'b1, 4));
        vecs.push_back(mkVec(8'h81, 1'b1, 0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mkVec(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 12));
        end

        foreach (vecs[i]) begin
            $display("[TB] vector %0d din=%02h ack=%0d pulses=%0d", i, vecs[i].din, vecs[i].ackLow, vecs[i].stopAfter);
            runVector(vecs[i], 0);
        end

        $display("[TB] request while busy");
        runVector(mkVec(PS2_CMD_SET_LED, 1'b1, 12), 3);

        $display("[TB] reset mid-frame then enable command");
        applyStimulus(mkVec(8'h96, 1'b1, 12), 0, 4, wasReset);
        checkOutput("midreset_taken", wasReset, 1);
        checkOutput("midreset_no_done", doneDelta, 0);
        checkOutput("midreset_no_err", errDelta, 0);
        checkOutput("midreset_end_idle", bus.tx_idle, 1);
        runVector(mkVec(PS2_CMD_ENABLE, 1'b1, 12), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
